keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad matrix scanner.
// Column strobing, whole-scan debounce and press/held/release reporting.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [3:0]    DEB      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_e;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic          cand_key;
  logic [3:0]    cand_code;
  logic          comm_key;
  logic [3:0]    comm_code;
  logic [3:0]    stable_cnt;

  logic          sample;
  logic          scan_end;
  logic [2:0]    low_cnt;
  logic [1:0]    low_row;
  logic [2:0]    sum;
  logic [1:0]    tot;
  logic [3:0]    code_nxt;
  res_e          res;
  logic          nxt_cand_key;
  logic [3:0]    nxt_cand_code;
  logic [3:0]    nxt_stable;
  logic          commit;

  assign col      = ~(4'b0001 << col_idx);
  assign sample   = (div_cnt == DIV_LAST);
  assign scan_end = sample && (col_idx == 2'd3);

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Count low rows in the current column and locate the low row.
  always_comb begin
    low_cnt = 3'd0;
    low_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        low_cnt = low_cnt + 3'd1;
        low_row = 2'(r);
      end
    end
  end

  // Fold this column into the running scan total (saturates at 2).
  always_comb begin
    sum      = {1'b0, acc_cnt} + low_cnt;
    tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_nxt = acc_code;
    if (acc_cnt == 2'd0 && low_cnt == 3'd1)
      code_nxt = {low_row, col_idx};
    unique case (tot)
      2'd0:    res = RES_NONE;
      2'd1:    res = RES_KEY;
      default: res = RES_MULTI;
    endcase
  end

  // Debounce next-state and commit decision for the end-of-scan edge.
  always_comb begin
    nxt_cand_key  = cand_key;
    nxt_cand_code = cand_code;
    nxt_stable    = stable_cnt;
    if (res == RES_MULTI) begin
      nxt_stable = 4'd0;
    end else if ((res == RES_KEY) != cand_key ||
                 (cand_key && code_nxt != cand_code)) begin
      nxt_cand_key  = (res == RES_KEY);
      nxt_cand_code = code_nxt;
      nxt_stable    = 4'd1;
    end else if (stable_cnt < DEB) begin
      nxt_stable = stable_cnt + 4'd1;
    end
    commit = scan_end && (res != RES_MULTI) && (nxt_stable == DEB) &&
             ((nxt_cand_key != comm_key) ||
              (nxt_cand_key && nxt_cand_code != comm_code));
  end

  // Column divider, column index and per-scan accumulator.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      col_idx  <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      if (scan_end) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= tot;
        acc_code <= code_nxt;
      end
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Debounce state, committed key and registered event outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cand_key    <= 1'b0;
      cand_code   <= 4'd0;
      comm_key    <= 1'b0;
      comm_code   <= 4'd0;
      stable_cnt  <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (scan_end) begin
        cand_key   <= nxt_cand_key;
        cand_code  <= nxt_cand_code;
        stable_cnt <= nxt_stable;
      end
      if (commit) begin
        comm_key  <= nxt_cand_key;
        comm_code <= nxt_cand_code;
        if (nxt_cand_key) begin
          key_code  <= nxt_cand_code;
          key_valid <= 1'b1;
          key_held  <= 1'b1;
        end else begin
          key_release <= 1'b1;
          key_held    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// Small matrix model drives rows from pressed-key mask and col.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;

  logic [15:0] keys = 16'h0000;

  int n_chk = 0;
  int n_err = 0;

  int valid_cnt = 0;
  int rel_cnt   = 0;
  int both_cnt  = 0;
  int wide_cnt  = 0;
  logic prev_v  = 1'b0;
  logic prev_r  = 1'b0;

  int v0;
  int r0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c])
          row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (key_valid) valid_cnt++;
      if (key_release) rel_cnt++;
      if (key_valid && key_release) both_cnt++;
      if ((key_valid && prev_v) || (key_release && prev_r)) wide_cnt++;
    end
    prev_v = key_valid;
    prev_r = key_release;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] ecol;

    // Test 1: reset and idle scanning.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_rel", 32'(key_release), 32'h0);
    for (int i = 0; i < 16; i++) begin
      ecol = 4'b1111;
      ecol[i/4] = 1'b0;
      check($sformatf("col%0d", i), 32'(col), 32'(ecol));
      @(negedge clk);
    end
    scans(9);
    check("idle_valid", 32'(valid_cnt), 32'd0);
    check("idle_rel", 32'(rel_cnt), 32'd0);
    check("idle_held", 32'(key_held), 32'h0);

    // Test 2: key 9 held for 6 scans.
    v0 = valid_cnt;
    keys = 16'h0200;
    scans(2);
    check("t2_nodeb", 32'(valid_cnt - v0), 32'd0);
    check("t2_held0", 32'(key_held), 32'h0);
    scans(1);
    check("t2_pulse", 32'(key_valid), 32'h1);
    check("t2_code", 32'(key_code), 32'h9);
    check("t2_held1", 32'(key_held), 32'h1);
    scans(3);
    check("t2_once", 32'(valid_cnt - v0), 32'd1);
    check("t2_held", 32'(key_held), 32'h1);

    // Test 3: release.
    v0 = valid_cnt;
    r0 = rel_cnt;
    keys = 16'h0000;
    scans(2);
    check("t3_held_pre", 32'(key_held), 32'h1);
    scans(1);
    check("t3_rel", 32'(key_release), 32'h1);
    check("t3_held", 32'(key_held), 32'h0);
    check("t3_code", 32'(key_code), 32'h9);
    scans(1);
    check("t3_nov", 32'(valid_cnt - v0), 32'd0);
    check("t3_rel1", 32'(rel_cnt - r0), 32'd1);

    // Test 4: key 9 on alternating scans.
    v0 = valid_cnt;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      scans(1);
    end
    keys = 16'h0000;
    check("t4_nov", 32'(valid_cnt - v0), 32'd0);
    check("t4_held", 32'(key_held), 32'h0);

    // Test 5: commit 9, then MULTI, then 5.
    keys = 16'h0200;
    scans(4);
    check("t5_code9", 32'(key_code), 32'h9);
    v0 = valid_cnt;
    r0 = rel_cnt;
    keys = 16'h2200;
    for (int i = 0; i < 5; i++) begin
      scans(1);
      check("t5_m_held", 32'(key_held), 32'h1);
      check("t5_m_code", 32'(key_code), 32'h9);
    end
    check("t5_m_nov", 32'(valid_cnt - v0), 32'd0);
    check("t5_m_norel", 32'(rel_cnt - r0), 32'd0);
    keys = 16'h0020;
    scans(2);
    check("t5_early", 32'(valid_cnt - v0), 32'd0);
    scans(1);
    check("t5_pulse", 32'(key_valid), 32'h1);
    check("t5_code5", 32'(key_code), 32'h5);
    check("t5_held", 32'(key_held), 32'h1);
    check("t5_norel", 32'(rel_cnt - r0), 32'd0);

    // Test 6: key 0 pressed, reset mid-scan.
    keys = 16'h0001;
    scans(2);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_col", 32'(col), 32'hE);
    check("t6_code", 32'(key_code), 32'h0);
    check("t6_held", 32'(key_held), 32'h0);
    check("t6_valid", 32'(key_valid), 32'h0);
    v0 = valid_cnt;
    r0 = rel_cnt;
    scans(2);
    check("t6_early", 32'(valid_cnt - v0), 32'd0);
    scans(1);
    check("t6_pulse", 32'(key_valid), 32'h1);
    check("t6_code0", 32'(key_code), 32'h0);
    check("t6_held1", 32'(key_held), 32'h1);
    check("t6_norel", 32'(rel_cnt - r0), 32'd0);
    scans(1);

    check("both_pulse", 32'(both_cnt), 32'd0);
    check("wide_pulse", 32'(wide_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
